imem_fetch_stage: RTL
=====================

Name: imem_fetch_stage

Overview:
Instruction-memory responder for the fetch stage. It consumes the word-addressed PC from the program-counter register (PC advances by 1 per instruction) and returns the addressed instruction through a registered IF/ID pipeline slot. The slot supports stall and flush from the hazard unit. A loader write port fills program memory while the core is held in reset.

Parameters:
ADDR_W, 8, word-address width; memory depth = 2^ADDR_W words
DATA_W, 32, instruction width in bits
NOP_INSTR, 32'h00000000, bubble instruction driven on flush, idle, reset or address error

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset of pipeline registers (not memory)
pc_in  input  32  word address of the instruction to fetch
pc_valid  input  1  pc_in carries a real fetch request this cycle
stall  input  1  hold IF/ID slot contents; no new fetch accepted
flush  input  1  kill IF/ID slot contents; inject bubble
ld_we  input  1  loader write enable
ld_addr  input  ADDR_W  loader word address
ld_data  input  DATA_W  loader write data
instr_out  output  DATA_W  IF/ID instruction
pc_out  output  32  IF/ID PC tagged to instr_out
instr_valid  output  1  IF/ID slot holds a real instruction
addr_err  output  1  sticky: a fetch targeted an address >= 2^ADDR_W

Behaviour:
- Reset (async, immediate): instr_out=NOP_INSTR, pc_out=0, instr_valid=0, addr_err=0. Memory contents are not cleared.
- Memory: 2^ADDR_W x DATA_W array.
  - Write port: on a clk edge with ld_we=1, mem[ld_addr]<=ld_data.
  - Writes are honoured even while rst=1; this is how programs are loaded.
- Per-edge priority, highest first (rst not asserted):
  1. flush=1: instr_out<=NOP_INSTR, instr_valid<=0, pc_out held. Flush overrides stall; the request on pc_in that cycle is dropped.
  2. stall=1: instr_out, pc_out and instr_valid all hold.
  3. pc_valid=1: fetch is accepted and pc_out<=pc_in.
     - In range (pc_in[31:ADDR_W]==0): instr_out<=mem[pc_in[ADDR_W-1:0]], instr_valid<=1.
     - Out of range: instr_out<=NOP_INSTR, instr_valid<=1, addr_err<=1.
  4. pc_valid=0: instr_out<=NOP_INSTR, instr_valid<=0, pc_out held.
- Latency: exactly 1 cycle from accepted pc_in to instr_out/pc_out. Back-to-back fetches sustain 1 instruction per cycle.
- Read/write collision: a fetch and a ld_we to the same address on the same edge returns the OLD word (read-before-write). The new word is visible from the next fetch.
- addr_err stays 1 until rst. It is set only by accepted fetches, never by flushed or stalled ones.
- Reset asserted mid-stream: outputs go to reset values immediately. The first fetch after rst deasserts behaves as a fresh request. No partial state survives.
- Boundaries:
  - pc_in = 2^ADDR_W-1 is the last valid word.
  - pc_in = 2^ADDR_W is out of range.
  - No wrap-around aliasing: upper bits are checked, never truncated.
- Indexing uses only pc_in[ADDR_W-1:0]. Address arithmetic is unsigned.

Test Plan:
- Load over the ld port with rst=1: mem[0..3]=32'h11111111, 22222222, 33333333, 44444444. Release rst. Drive pc_in=0,1,2,3 with pc_valid=1 on consecutive cycles. Required: instr_out equals those four words one cycle later each, pc_out=0..3, instr_valid=1.
- Streaming pc 0..3, assert stall for 2 cycles while pc_out=1. Required: instr_out=22222222 and pc_out=1 held both cycles; after release, the next accepted pc_in appears 1 cycle later.
- flush=1 and stall=1 on the same edge while holding pc=2. Required: next cycle instr_out=NOP_INSTR, instr_valid=0, pc_out=2.
- With ADDR_W=8, fetch pc_in=255, then pc_in=256. Required: mem[255] returned with addr_err=0; then NOP_INSTR, instr_valid=1, addr_err=1, and addr_err still 1 ten cycles later with pc_valid=0.
- Same edge: ld_we=1, ld_addr=5, ld_data=32'hDEADBEEF and a fetch of pc_in=5 (old word 32'hAAAA0005). Required: instr_out=AAAA0005; an immediate refetch of pc 5 returns DEADBEEF.
- Assert rst asynchronously mid-cycle during streaming. Required: outputs go to 0/NOP/0/0 before the next edge; mem contents intact, so after release a fetch of pc 0 returns 11111111.

Source files
------------

// File: rtl/imem_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : imem_fetch_stage
//  Purpose  : Instruction-memory responder for the fetch stage. Returns the
//             word addressed by a word-granular PC through a registered IF/ID
//             slot that supports stall and flush. A loader write port fills
//             program memory, including while the core is held in reset.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W      word-address width; memory depth = 2**ADDR_W words
//    DATA_W      instruction width in bits
//    NOP_INSTR   bubble driven on flush, idle, reset or address error
//  Ports
//    clk          in   system clock, rising-edge active
//    rst          in   asynchronous active-high reset of the IF/ID slot
//    pc_in        in   [31:0]  word address to fetch
//    pc_valid     in   pc_in carries a real fetch request
//    stall        in   hold IF/ID slot, accept no new fetch
//    flush        in   kill IF/ID slot, inject bubble
//    ld_we        in   loader write enable
//    ld_addr      in   [ADDR_W-1:0] loader word address
//    ld_data      in   [DATA_W-1:0] loader write data
//    instr_out    out  [DATA_W-1:0] IF/ID instruction
//    pc_out       out  [31:0] PC tagged to instr_out
//    instr_valid  out  IF/ID slot holds a real instruction
//    addr_err     out  sticky flag: an accepted fetch was out of range
// ============================================================================
module imem_fetch_stage #(
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_in,
  input  logic              pc_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] instr_out,
  output logic [31:0]       pc_out,
  output logic              instr_valid,
  output logic              addr_err
);

  localparam int unsigned C_DEPTH = 1 << ADDR_W;

  // Program memory. Deliberately has no reset so a program loaded while the
  // core sits in reset survives reset release.
  logic [DATA_W-1:0] r_mem [C_DEPTH];

  logic [ADDR_W-1:0] w_idx;
  logic              w_in_range;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_accept;

  assign w_idx = pc_in[ADDR_W-1:0];

  // The upper PC bits are checked, never truncated, so an address past the
  // end of memory cannot alias back onto a low word.
  generate
    if (ADDR_W < 32) begin : g_range_chk
      assign w_in_range = (pc_in[31:ADDR_W] == '0);
    end else begin : g_full_range
      assign w_in_range = 1'b1;
    end
  endgenerate

  // Combinational read sampled into the slot on the same edge as a loader
  // write; with non-blocking updates this yields the old word on collision.
  assign w_rd_data = r_mem[w_idx];

  // A fetch is taken only when nothing higher-priority claims the edge.
  assign w_accept = pc_valid & ~stall & ~flush;

  // Loader port, honoured regardless of rst.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

  // IF/ID slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_out   <= NOP_INSTR;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else if (flush) begin
      // Flush wins over stall; pc_out keeps its last tag.
      instr_out   <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else if (stall) begin
      instr_out   <= instr_out;
      pc_out      <= pc_out;
      instr_valid <= instr_valid;
    end else if (w_accept) begin
      pc_out      <= pc_in;
      instr_valid <= 1'b1;
      if (w_in_range) begin
        instr_out <= w_rd_data;
      end else begin
        // Out-of-range fetch still occupies the slot, carrying a bubble.
        instr_out <= NOP_INSTR;
        addr_err  <= 1'b1;
      end
    end else begin
      instr_out   <= NOP_INSTR;
      instr_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
